// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV64 memory-access stage: load/store over the data-bus
// request/response handshake, load extension, write-back packet output.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_result,
  input  logic [63:0] in_store_data,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_regwrite
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_next;
  logic        is_load_in, is_store_in, is_mem_in;
  logic        accept, resp_done;
  logic [2:0]  in_off;
  logic [7:0]  base_mask;
  logic [7:0]  store_strobe;
  logic [63:0] store_lanes;
  logic        lat_load;
  logic [2:0]  lat_funct3;
  logic [63:0] load_raw;
  logic [63:0] load_ext;

  assign is_load_in  = (in_opcode == OP_LOAD);
  assign is_store_in = (in_opcode == OP_STORE);
  assign is_mem_in   = is_load_in | is_store_in;

  assign in_ready   = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign dreq_valid = (state == S_REQ);
  assign out_valid  = (state == S_DONE);

  // The bus transaction completes on data_ok, but only once the address has been taken.
  assign resp_done = ((state == S_REQ) & dresp_addr_ok & dresp_data_ok) |
                     ((state == S_WAIT) & dresp_data_ok);

  // Store lane placement; the 8-bit shift drops lanes past byte 7.
  assign in_off = in_result[2:0];

  always_comb begin
    base_mask = 8'h01;
    case (in_funct3[1:0])
      2'd0: base_mask = 8'h01;
      2'd1: base_mask = 8'h03;
      2'd2: base_mask = 8'h0F;
      2'd3: base_mask = 8'hFF;
      default: base_mask = 8'h01;
    endcase
  end

  assign store_strobe = base_mask << in_off;
  assign store_lanes  = in_store_data << {in_off, 3'b000};

  // Load extraction uses the latched address offset and access type.
  assign load_raw = dresp_data >> {dreq_addr[2:0], 3'b000};

  always_comb begin
    load_ext = 64'd0;
    case (lat_funct3[1:0])
      2'd0: load_ext = lat_funct3[2] ? {56'd0, load_raw[7:0]}
                                     : {{56{load_raw[7]}}, load_raw[7:0]};
      2'd1: load_ext = lat_funct3[2] ? {48'd0, load_raw[15:0]}
                                     : {{48{load_raw[15]}}, load_raw[15:0]};
      2'd2: load_ext = lat_funct3[2] ? {32'd0, load_raw[31:0]}
                                     : {{32{load_raw[31]}}, load_raw[31:0]};
      2'd3: load_ext = load_raw;
      default: load_ext = 64'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = is_mem_in ? S_REQ : S_DONE;
      end
      S_REQ: begin
        if (dresp_addr_ok & dresp_data_ok) state_next = S_DONE;
        else if (dresp_addr_ok)            state_next = S_WAIT;
      end
      S_WAIT: begin
        if (dresp_data_ok) state_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (accept) state_next = is_mem_in ? S_REQ : S_DONE;
          else        state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dreq_addr    <= 64'd0;
      dreq_size    <= 3'd0;
      dreq_strobe  <= 8'd0;
      dreq_data    <= 64'd0;
      lat_load     <= 1'b0;
      lat_funct3   <= 3'd0;
      out_data     <= 64'd0;
      out_rd       <= 5'd0;
      out_regwrite <= 1'b0;
    end else if (accept) begin
      lat_load     <= is_load_in;
      lat_funct3   <= in_funct3;
      out_rd       <= in_rd;
      out_regwrite <= in_regwrite & ~is_store_in;
      out_data     <= is_mem_in ? 64'd0 : in_result;
      // Request fields only move on a memory accept so they stay stable through REQ.
      if (is_mem_in) begin
        dreq_addr   <= in_result;
        dreq_size   <= {1'b0, in_funct3[1:0]};
        dreq_strobe <= is_store_in ? store_strobe : 8'd0;
        dreq_data   <= is_store_in ? store_lanes : 64'd0;
      end
    end else if (resp_done & lat_load) begin
      out_data <= load_ext;
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV64 pipeline, directly downstream of the EX-stage ALU. It consumes the ALU result (effective address or computed value) with its decoded control, runs loads and stores over the data-bus request/response handshake, and extends load data. It then presents a write-back packet to the next stage. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- none; widths fixed: 64-bit address and data.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  EX packet valid.
- `in_ready`  out  1  stage can accept a packet this cycle.
- `in_result`  in  64  ALU result: address for load/store, value otherwise.
- `in_store_data`  in  64  rs2 value for stores.
- `in_opcode`  in  7  instruction opcode.
- `in_funct3`  in  3  instruction funct3.
- `in_rd`  in  5  destination register.
- `in_regwrite`  in  1  packet writes rd.
- `dreq_valid`  out  1  data-bus request valid.
- `dreq_addr`  out  64  request address (`in_result`, unmodified).
- `dreq_size`  out  3  0=1B, 1=2B, 2=4B, 3=8B.
- `dreq_strobe`  out  8  byte-lane write enables; 0 for loads.
- `dreq_data`  out  64  lane-aligned store data.
- `dresp_addr_ok`  in  1  bus accepted address.
- `dresp_data_ok`  in  1  bus completed; `dresp_data` valid.
- `dresp_data`  in  64  read data (whole aligned doubleword).
- `out_valid`  out  1  write-back packet valid.
- `out_ready`  in  1  write-back stage accepts.
- `out_data`  out  64  value to write to rd.
- `out_rd`  out  5  destination register.
- `out_regwrite`  out  1  write enable.

## Operation
- Load: opcode 0000011, funct3 0..6 = LB, LH, LW, LD, LBU, LHU, LWU.
- Store: opcode 0100011, funct3 0..3 = SB, SH, SW, SD.
- Any other opcode is pass-through with `out_data = in_result`.
- Packet fields are latched on acceptance (`in_valid & in_ready`).
- FSM states:
  - IDLE: on accept, go to REQ for a load or store, else to DONE.
  - REQ: `dreq_valid=1`.
    - `addr_ok & data_ok` in the same cycle: go to DONE.
    - `addr_ok` only: go to WAIT.
    - Neither: stay in REQ.
  - WAIT: `dreq_valid=0`; on `data_ok`, go to DONE.
  - DONE: `out_valid=1`.
    - On `out_ready`: go to IDLE, or accept a new packet directly if `in_valid`. The new packet's next state follows the IDLE rule.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
- All `dreq_*` outputs stay stable from REQ entry until `addr_ok`.
- Let `off = addr[2:0]`.
- Store request:
  - `dreq_size = funct3[1:0]`.
  - `dreq_strobe = ({1,3,15,255}[size] << off) & 8'hFF`.
  - `dreq_data = store_data << (8*off)`.
- Load request: `dreq_size = funct3[1:0]`, `dreq_strobe = 0`.
- Load data: `raw = dresp_data >> (8*off)`, truncated to the access size. Sign-extend for funct3 < 4, zero-extend otherwise. The result is captured into `out_data` on `data_ok`.
- Stores: `out_regwrite` is forced to 0 and `out_data = 0`.
- Misalignment is not checked. Lanes shifted beyond byte 7 are dropped.

## Timing
- Reset (asynchronous) forces state IDLE.
- Reset values: `dreq_valid=0`, `out_valid=0`, `out_data=0`, `out_rd=0`, `out_regwrite=0`; all `dreq_*` data fields 0; `in_ready=1` on the first cycle after deassertion.
- Reset mid-transaction abandons the access. `dreq_valid` falls immediately without waiting for a clock edge, and a later `data_ok` is ignored in IDLE.
- Pass-through latency is 1 cycle: accept at edge N, `out_valid` from N.
- Memory latency:
  - Accept at N, REQ in cycle N.
  - With `addr_ok & data_ok` in that cycle, `out_valid` in cycle N+1.
  - Each stall cycle adds 1.
- While `out_valid & !out_ready`, the stage holds the packet and `in_ready=0`.
- Sustained pass-through with `out_ready=1` gives 1 packet/cycle.
- `dresp_*` inputs are ignored in IDLE and DONE.

## Test plan
- ADDI pass-through: `in_result=0x1234`, rd=5, `out_ready=1` -> `out_valid` next cycle, `out_data=0x1234`, `out_rd=5`, `dreq_valid` never 1.
- SB: addr `0x8000_0003`, data `0xAB` -> `dreq_size=0`, `dreq_strobe=0x08`, `dreq_data[31:24]=0xAB`, `out_regwrite=0`.
- LB: addr `0x...06`, `dresp_data=0x0080_0000_0000_0000` -> `out_data=0xFFFF_FFFF_FFFF_FF80`. LBU on the same data -> `0x80`.
- LW with bus delays: `addr_ok` after 2 cycles, `data_ok` 3 cycles later.
  - `dreq_valid` is high exactly 3 cycles with stable fields.
  - `out_valid` appears 1 cycle after `data_ok`.
  - `in_ready=0` throughout.
- Back-pressure: `out_ready=0` for 4 cycles in DONE -> outputs held, `in_ready=0`. Then `out_ready=1` with `in_valid=1` -> the next packet is accepted the same cycle.
- Reset asserted in WAIT -> `dreq_valid=0` and `out_valid=0` immediately. A stray `data_ok` after reset produces no output.
